// File: rtl/hilo_divider.sv
// Iterative radix-2 restoring divider for div/divu: quotient to LO, remainder to HI.
// Optional squash input Flush is compiled in when HILO_DIV_FLUSH_EN is defined.
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef HILO_DIV_FLUSH_EN
    input  logic             Flush,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] QuotientLO,
    output logic [WIDTH-1:0] RemainderHI,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_out_q, dbz_out_d;

    logic             flush;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh;

`ifdef HILO_DIV_FLUSH_EN
    assign flush = Flush;
`else
    assign flush = 1'b0;
`endif

    // Magnitudes stay WIDTH bits unsigned, so the most negative value maps onto itself.
    assign a_mag  = (Signed && A[WIDTH-1]) ? -A : A;
    assign b_mag  = (Signed && B[WIDTH-1]) ? -B : B;
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};

    always_comb begin
        // NOTE: every signal assigned here gets its hold value first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        a_d       = a_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_out_d = dbz_out_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Start && !flush) begin
                    a_d       = A;
                    dvsr_d    = b_mag;
                    quo_d     = a_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = Signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_rem_d = Signed && A[WIDTH-1];
                    zero_d    = (B == '0);
                    // A zero divisor skips iteration but still spends one busy cycle in FIX.
                    state_d   = (B == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                if (rem_sh >= {1'b0, dvsr_q}) begin
                    rem_d = WIDTH'(rem_sh - {1'b0, dvsr_q});
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quo_out_d = '1;
                    rem_out_d = a_q;
                    dbz_out_d = 1'b1;
                end else begin
                    quo_out_d = neg_quo_q ? -quo_q : quo_q;
                    rem_out_d = neg_rem_q ? -rem_q : rem_q;
                    dbz_out_d = 1'b0;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (flush && (state_q == RUN || state_q == FIX)) begin
            state_d   = IDLE;
            quo_out_d = quo_out_q;
            rem_out_d = rem_out_q;
            dbz_out_d = dbz_out_q;
        end
    end

    // NOTE: sequential state updates use non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            a_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            a_q       <= a_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign Busy        = (state_q == RUN) || (state_q == FIX);
    assign Done        = (state_q == DONE);
    assign QuotientLO  = quo_out_q;
    assign RemainderHI = rem_out_q;
    assign DivByZero   = dbz_out_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed bench for hilo_divider; covers the Flush path when HILO_DIV_FLUSH_EN is defined.
module tb_hilo_divider;

    localparam int W = 32;

    logic         Clk    = 1'b0;
    logic         Reset  = 1'b0;
    logic         Start  = 1'b0;
    logic         Signed = 1'b0;
    logic [W-1:0] A      = '0;
    logic [W-1:0] B      = '0;
`ifdef HILO_DIV_FLUSH_EN
    logic         Flush  = 1'b0;
`endif
    logic         Busy;
    logic         Done;
    logic [W-1:0] QuotientLO;
    logic [W-1:0] RemainderHI;
    logic         DivByZero;

    int n_cmp = 0;
    int n_bad = 0;

    hilo_divider #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Signed     (Signed),
        .A          (A),
        .B          (B),
`ifdef HILO_DIV_FLUSH_EN
        .Flush      (Flush),
`endif
        .Busy       (Busy),
        .Done       (Done),
        .QuotientLO (QuotientLO),
        .RemainderHI(RemainderHI),
        .DivByZero  (DivByZero)
    );

    always #5 Clk = ~Clk;

    // Entered #1 after some edge, in cycle 'first' after the capture edge; stops in the Done cycle.
    task automatic wait_done(input int first, input logic [W-1:0] hold_q, input logic [W-1:0] hold_r,
                             output int lat, output int busy_cnt, output int hold_err);
        lat      = first;
        busy_cnt = 0;
        hold_err = 0;
        while (Done !== 1'b1 && lat <= 100) begin
            if (Busy === 1'b1) busy_cnt++;
            if (QuotientLO !== hold_q || RemainderHI !== hold_r) hold_err++;
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic do_div(input string name, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_lat, input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        logic [W-1:0] pq, pr;
        int lat, bc, he;
        pq = QuotientLO;
        pr = RemainderHI;
        Signed = sgn; A = a; B = b; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        wait_done(1, pq, pr, lat, bc, he);
        n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
        n_cmp++; if (bc !== exp_lat - 1) begin n_bad++; $display("FAIL %s busy_cycles got %0d want %0d", name, bc, exp_lat - 1); end
        n_cmp++; if (he !== 0) begin n_bad++; $display("FAIL %s output_hold got %0d changes want 0", name, he); end
        n_cmp++; if (QuotientLO !== eq) begin n_bad++; $display("FAIL %s quotient got %h want %h", name, QuotientLO, eq); end
        n_cmp++; if (RemainderHI !== er) begin n_bad++; $display("FAIL %s remainder got %h want %h", name, RemainderHI, er); end
        n_cmp++; if (DivByZero !== edbz) begin n_bad++; $display("FAIL %s divbyzero got %b want %b", name, DivByZero, edbz); end
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_in_done got %b want 0", name, Busy); end
        @(posedge Clk); #1;
        n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL %s done_width got %b want 0", name, Done); end
    endtask

    task automatic test_reset();
        Start = 1'b1; A = 32'd100; B = 32'd7;
        repeat (3) @(posedge Clk);
        #1;
        n_cmp++; if ({Busy, Done, DivByZero} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {Busy, Done, DivByZero}); end
        n_cmp++; if ({QuotientLO, RemainderHI} !== 64'd0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", {QuotientLO, RemainderHI}); end
        Start = 1'b0;
        Reset = 1'b1;
        @(posedge Clk); #1;
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_start_ignored busy got %b want 0", Busy); end
    endtask

    task automatic test_unsigned();
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);
    endtask

    task automatic test_signed();
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 32'd1, 1'b0);
    endtask

    task automatic test_overflow();
        do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0, 1'b0);
        do_div("divu_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_div_by_zero();
        do_div("divu_by_zero", 1'b0, 32'h1234_5678, 32'd0, 2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        do_div("div_after_zero", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_back_to_back();
        int lat, bc, he;
        logic [W-1:0] pq, pr;
        pq = QuotientLO;
        pr = RemainderHI;
        Signed = 1'b0; A = 32'd50; B = 32'd5; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        A = 32'd9; B = 32'd3; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; A = '0; B = '0;
        wait_done(11, pq, pr, lat, bc, he);
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 34", lat); end
        n_cmp++; if (he !== 0) begin n_bad++; $display("FAIL b2b_first_hold got %0d changes want 0", he); end
        n_cmp++; if ({QuotientLO, RemainderHI} !== {32'd10, 32'd0}) begin n_bad++; $display("FAIL b2b_first_result got %h want %h", {QuotientLO, RemainderHI}, {32'd10, 32'd0}); end
        A = 32'd9; B = 32'd3; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; A = '0; B = '0;
        n_cmp++; if ({Busy, Done} !== 2'b10) begin n_bad++; $display("FAIL b2b_restart got busy/done %b want 10", {Busy, Done}); end
        wait_done(1, 32'd10, 32'd0, lat, bc, he);
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 34", lat); end
        n_cmp++; if ({QuotientLO, RemainderHI} !== {32'd3, 32'd0}) begin n_bad++; $display("FAIL b2b_second_result got %h want %h", {QuotientLO, RemainderHI}, {32'd3, 32'd0}); end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_abort();
        int dones, busys;
        Signed = 1'b0; A = 32'd50; B = 32'd5; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (14) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        n_cmp++; if ({Busy, Done, DivByZero} !== 3'b000) begin n_bad++; $display("FAIL abort_flags got %b want 000", {Busy, Done, DivByZero}); end
        n_cmp++; if ({QuotientLO, RemainderHI} !== 64'd0) begin n_bad++; $display("FAIL abort_outputs got %h want 0", {QuotientLO, RemainderHI}); end
        dones = 0; busys = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) dones++;
            if (Busy === 1'b1) busys++;
            @(posedge Clk); #1;
        end
        n_cmp++; if ({dones, busys} !== 64'd0) begin n_bad++; $display("FAIL abort_quiet got done=%0d busy=%0d want 0/0", dones, busys); end
    endtask

`ifdef HILO_DIV_FLUSH_EN
    task automatic test_flush();
        int dones;
        do_div("flush_pre", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);
        Signed = 1'b0; A = 32'd50; B = 32'd5; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (14) @(posedge Clk);
        #1;
        Flush = 1'b1;
        @(posedge Clk); #1;
        Flush = 1'b0;
        n_cmp++; if ({Busy, Done, DivByZero} !== 3'b000) begin n_bad++; $display("FAIL flush_flags got %b want 000", {Busy, Done, DivByZero}); end
        n_cmp++; if ({QuotientLO, RemainderHI} !== {32'd14, 32'd2}) begin n_bad++; $display("FAIL flush_retained got %h want %h", {QuotientLO, RemainderHI}, {32'd14, 32'd2}); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) dones++;
            @(posedge Clk); #1;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL flush_no_done got %0d want 0", dones); end
        A = 32'd9; B = 32'd3; Start = 1'b1; Flush = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; Flush = 1'b0;
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL flush_blocks_start busy got %b want 0", Busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_div_by_zero();
        test_reset_abort();
`ifdef HILO_DIV_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
